bmp_loader: RTL and testbench

- Sits between data_io and the SDRAM write port in the MENU core.
- Parses the header of a downloaded BMP file and validates it.
- Converts 24bpp BGR pixel bytes into 32-bit {8'h00,R,G,B} pixels and queues them in a small FIFO.
- Writes each pixel to SDRAM as two 16-bit words using the toggle req/ack handshake, and tells the video path when a valid background image is present.

---
 rtl/bmp_loader_pkg.sv | 43 ++++
 rtl/bmp_wr_fifo.sv | 58 +++++
 rtl/bmp_loader.sv | 247 ++++++++++++++++++++++++
 tb/tb_bmp_loader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmp_loader_pkg.sv
// Shared types and constants for the BMP background loader.
package bmp_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StSkip,
    StPixel,
    StDrain,
    StDone,
    StError
  } state_e;

  localparam int unsigned OffSig     = 0;
  localparam int unsigned OffDataOff = 10;
  localparam int unsigned OffWidth   = 18;
  localparam int unsigned OffHeight  = 22;
  localparam int unsigned OffBpp     = 28;
  localparam int unsigned OffLast    = 29;
  localparam int unsigned MinDataOff = 30;

  localparam logic [15:0] BmpSig = 16'h4D42;  // "BM", little-endian

  localparam logic [2:0] ErrNone     = 3'd0;
  localparam logic [2:0] ErrSig      = 3'd1;
  localparam logic [2:0] ErrBpp      = 3'd2;
  localparam logic [2:0] ErrGeometry = 3'd3;
  localparam logic [2:0] ErrOverflow = 3'd4;
  localparam logic [2:0] ErrTrunc    = 3'd5;

  typedef struct packed {
    logic [21:0] addr;
    logic [15:0] d;
  } fifo_entry_t;

  // Bytes of row padding: (4 - (3*width mod 4)) mod 4, only the width LSBs matter.
  function automatic logic [1:0] row_pad(input logic [1:0] w_lsb);
    logic [1:0] m;
    m = w_lsb * 2'd3;
    return 2'd0 - m;
  endfunction

endpackage

// File: rtl/bmp_wr_fifo.sv
// Small synchronous FIFO of SDRAM write entries with full/empty flags and a count.
module bmp_wr_fifo
  import bmp_loader_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     clr,
  input  logic                     push,
  input  fifo_entry_t              wdata,
  input  logic                     pop,
  output fifo_entry_t              rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned AddrW = $clog2(Depth);

  fifo_entry_t      mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             do_push, do_pop;

  // Depth is a power of two, so the count MSB alone means full.
  assign full    = count_q[AddrW];
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/bmp_loader.sv
// Parses a downloaded 24bpp BMP, converts pixels and writes them to SDRAM via req/ack toggles.
module bmp_loader
  import bmp_loader_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned MAX_HEIGHT = 312,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [21:0] BASE_ADDR  = 22'd0,
  parameter logic [7:0]  FILE_INDEX = 8'd1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [26:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        port_req,
  input  logic        port_ack,
  output logic [21:0] port_a,
  output logic [1:0]  port_ds,
  output logic [15:0] port_d,
  output logic        port_we,
  output logic        bmp_loaded,
  output logic        bmp_error,
  output logic [2:0]  err_code
);

  state_e      state_q, state_d;
  logic        wr_q, dl_q, accept, start, pop, push, fail, row_done, geom_bad;
  logic [2:0]  fail_code;
  logic [15:0] sig_q, sig_d;
  logic [31:0] off_q, off_d, width_q, width_d, height_q, height_d;
  logic [7:0]  bpp_q, bpp_d, b_q, b_d;
  logic [15:0] row_q, row_d, col_q, col_d;
  logic [1:0]  phase_q, phase_d, pad_q, pad_d;
  logic        in_pad_q, in_pad_d, loaded_q, loaded_d, error_q, error_d;
  logic [2:0]  code_q, code_d;
  logic [21:0] pix_idx, pix_addr;
  fifo_entry_t push_data, head;
  logic        fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign accept = ioctl_wr && !wr_q && ioctl_download && (ioctl_index == FILE_INDEX);
  assign start  = ioctl_download && !dl_q && (ioctl_index == FILE_INDEX);
  assign pop    = !fifo_empty && (port_ack == port_req) && (state_q != StError) && !start;

  assign geom_bad = (width_q == '0) || (width_q > 32'(IMG_WIDTH)) || (height_q == '0) ||
                    (height_q > 32'(MAX_HEIGHT)) || (off_q < 32'(MinDataOff));

  assign pix_idx  = 22'(row_q) * 22'(IMG_WIDTH) + 22'(col_q);
  assign pix_addr = BASE_ADDR + (pix_idx << 1);

  assign port_ds    = 2'b11;
  assign bmp_loaded = loaded_q;
  assign bmp_error  = error_q;
  assign err_code   = code_q;

  bmp_wr_fifo #(.Depth(FIFO_DEPTH)) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .clr     (start || (state_q == StError)),
    .push    (push),
    .wdata   (push_data),
    .pop     (pop),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    sig_d     = sig_q;
    off_d     = off_q;
    width_d   = width_q;
    height_d  = height_q;
    bpp_d     = bpp_q;
    row_d     = row_q;
    col_d     = col_q;
    phase_d   = phase_q;
    pad_d     = pad_q;
    in_pad_d  = in_pad_q;
    b_d       = b_q;
    loaded_d  = loaded_q;
    error_d   = error_q;
    code_d    = code_q;
    push      = 1'b0;
    push_data = '0;
    row_done  = 1'b0;
    fail      = 1'b0;
    fail_code = ErrNone;
    case (state_q)
      StHeader: if (accept) begin
        for (int i = 0; i < 4; i++) begin
          if (ioctl_addr == 27'(OffDataOff + i)) off_d[8*i +: 8] = ioctl_dout;
          if (ioctl_addr == 27'(OffWidth + i))   width_d[8*i +: 8] = ioctl_dout;
          if (ioctl_addr == 27'(OffHeight + i))  height_d[8*i +: 8] = ioctl_dout;
        end
        if (ioctl_addr == 27'(OffSig))     sig_d[7:0]  = ioctl_dout;
        if (ioctl_addr == 27'(OffSig + 1)) sig_d[15:8] = ioctl_dout;
        if (ioctl_addr == 27'(OffBpp))     bpp_d       = ioctl_dout;
        if (ioctl_addr == 27'(OffLast)) begin
          // bpp high byte arrives now, so the check uses it directly.
          if (sig_q != BmpSig) begin
            fail = 1'b1; fail_code = ErrSig;
          end else if ({ioctl_dout, bpp_q} != 16'd24) begin
            fail = 1'b1; fail_code = ErrBpp;
          end else if (geom_bad) begin
            fail = 1'b1; fail_code = ErrGeometry;
          end else begin
            state_d = StSkip;
          end
        end
      end
      StSkip: if (accept && ({5'b0, ioctl_addr} == off_q)) begin
        state_d  = StPixel;
        row_d    = '0;
        col_d    = '0;
        in_pad_d = 1'b0;
        b_d      = ioctl_dout;
        phase_d  = 2'd1;
      end
      StPixel: if (accept) begin
        if (in_pad_q) begin
          pad_d = pad_q - 1'b1;
          if (pad_q == 2'd1) row_done = 1'b1;
        end else begin
          case (phase_q)
            2'd0: begin
              b_d     = ioctl_dout;
              phase_d = 2'd1;
            end
            2'd1: begin
              push      = 1'b1;
              push_data = '{addr: pix_addr, d: {ioctl_dout, b_q}};
              phase_d   = 2'd2;
            end
            default: begin
              push      = 1'b1;
              push_data = '{addr: pix_addr + 22'd1, d: {8'h00, ioctl_dout}};
              phase_d   = 2'd0;
              col_d     = col_q + 16'd1;
              if (32'(col_q) + 32'd1 == width_q) begin
                if (row_pad(width_q[1:0]) != 2'd0) begin
                  in_pad_d = 1'b1;
                  pad_d    = row_pad(width_q[1:0]);
                end else begin
                  row_done = 1'b1;
                end
              end
            end
          endcase
        end
        if (row_done) begin
          col_d    = '0;
          in_pad_d = 1'b0;
          row_d    = row_q + 16'd1;
          if (32'(row_q) + 32'd1 == height_q) state_d = StDrain;
        end
      end
      StDrain: if ((fifo_count == '0) && (port_ack == port_req)) begin
        loaded_d = 1'b1;
        state_d  = StDone;
      end
      default: ;
    endcase

    if (!ioctl_download && (state_q inside {StHeader, StSkip, StPixel})) begin
      fail = 1'b1; fail_code = ErrTrunc;
    end
    if (push && fifo_full && !pop) begin
      fail = 1'b1; fail_code = ErrOverflow;
    end
    if (fail) begin
      state_d  = StError;
      error_d  = 1'b1;
      code_d   = fail_code;
      loaded_d = 1'b0;
    end
    if (start) begin
      state_d  = StHeader;
      loaded_d = 1'b0;
      error_d  = 1'b0;
      code_d   = ErrNone;
      push     = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      wr_q     <= 1'b0;
      dl_q     <= 1'b0;
      sig_q    <= '0;
      off_q    <= '0;
      width_q  <= '0;
      height_q <= '0;
      bpp_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      phase_q  <= '0;
      pad_q    <= '0;
      in_pad_q <= 1'b0;
      b_q      <= '0;
      loaded_q <= 1'b0;
      error_q  <= 1'b0;
      code_q   <= ErrNone;
    end else begin
      state_q  <= state_d;
      wr_q     <= ioctl_wr;
      dl_q     <= ioctl_download;
      sig_q    <= sig_d;
      off_q    <= off_d;
      width_q  <= width_d;
      height_q <= height_d;
      bpp_q    <= bpp_d;
      row_q    <= row_d;
      col_q    <= col_d;
      phase_q  <= phase_d;
      pad_q    <= pad_d;
      in_pad_q <= in_pad_d;
      b_q      <= b_d;
      loaded_q <= loaded_d;
      error_q  <= error_d;
      code_q   <= code_d;
    end
  end

  // One request in flight at a time; an outstanding one may finish even in error.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      port_req <= 1'b0;
      port_we  <= 1'b0;
      port_a   <= '0;
      port_d   <= '0;
    end else if (pop) begin
      port_req <= ~port_req;
      port_we  <= 1'b1;
      port_a   <= head.addr;
      port_d   <= head.d;
    end else if ((port_ack == port_req) && fifo_empty) begin
      port_we  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bmp_loader.sv
// Directed self-checking bench for bmp_loader with a 3-cycle SDRAM ack model.
module tb_bmp_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [26:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        port_req, port_ack, port_we, bmp_loaded, bmp_error;
  logic [21:0] port_a;
  logic [1:0]  port_ds;
  logic [15:0] port_d;
  logic [2:0]  err_code;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        ack_hold = 1'b0;
  logic [1:0]  ack_cnt;
  logic        req_prev;
  int          n_wr = 0;
  int          base;
  int          bad_seq;
  logic [21:0] wa [8192];
  logic [15:0] wd [8192];

  always #5 clk_sys = ~clk_sys;

  bmp_loader u_dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .port_req       (port_req),
    .port_ack       (port_ack),
    .port_a         (port_a),
    .port_ds        (port_ds),
    .port_d         (port_d),
    .port_we        (port_we),
    .bmp_loaded     (bmp_loaded),
    .bmp_error      (bmp_error),
    .err_code       (err_code)
  );

  // SDRAM: acknowledge three cycles after each request toggle unless held.
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      port_ack <= 1'b0;
      ack_cnt  <= 2'd0;
    end else if ((port_req != port_ack) && !ack_hold) begin
      if (ack_cnt == 2'd2) begin
        port_ack <= port_req;
        ack_cnt  <= 2'd0;
      end else begin
        ack_cnt <= ack_cnt + 2'd1;
      end
    end
  end

  // Record every request toggle with its address and data.
  always @(negedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      req_prev <= 1'b0;
    end else begin
      if (port_req !== req_prev) begin
        wa[n_wr] <= port_a;
        wd[n_wr] <= port_d;
        n_wr     <= n_wr + 1;
      end
      req_prev <= port_req;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input int addr, input logic [7:0] b);
    @(negedge clk_sys);
    ioctl_addr = 27'(addr);
    ioctl_dout = b;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic start_dl();
    @(negedge clk_sys);
    ioctl_index    = 8'd1;
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic end_dl();
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic send_header(input logic [7:0] sig1, input logic [31:0] w, input logic [31:0] h,
                             input logic [15:0] bpp);
    logic [31:0] off;
    off = 32'd54;
    for (int i = 0; i < 54; i++) begin
      logic [7:0] b;
      b = 8'h00;
      case (i)
        0:  b = 8'h42;
        1:  b = sig1;
        10: b = off[7:0];
        11: b = off[15:8];
        12: b = off[23:16];
        13: b = off[31:24];
        18: b = w[7:0];
        19: b = w[15:8];
        20: b = w[23:16];
        21: b = w[31:24];
        22: b = h[7:0];
        23: b = h[15:8];
        24: b = h[23:16];
        25: b = h[31:24];
        26: b = 8'h01;
        28: b = bpp[7:0];
        29: b = bpp[15:8];
        default: b = 8'h00;
      endcase
      send_byte(i, b);
    end
  endtask

  task automatic wait_end(input string tag, input int budget);
    int i;
    i = 0;
    while (!(bmp_loaded || bmp_error) && i < budget) begin
      @(negedge clk_sys);
      i++;
    end
    repeat (3) @(negedge clk_sys);
    chk(tag, 32'(i >= budget), 32'd0);
  endtask

  function automatic logic [7:0] pix640(input int k);
    case (k)
      0: return 8'h11;
      1: return 8'h22;
      2: return 8'h33;
      default: return 8'(k);
    endcase
  endfunction

  // 3-wide rows: 9 pixel bytes then 3 pad bytes of 8'hEE.
  function automatic logic [7:0] pix3(input int k);
    int r, j;
    r = k / 12;
    j = k % 12;
    if (j < 9) return 8'(r * 64 + j + 1);
    return 8'hEE;
  endfunction

  task automatic load_3x2(input string tag);
    start_dl();
    base = n_wr;
    send_header(8'h4D, 32'd3, 32'd2, 16'd24);
    for (int k = 0; k < 24; k++) send_byte(54 + k, pix3(k));
    wait_end({tag, "_timeout"}, 500);
    end_dl();
    chk({tag, "_loaded"}, 32'(bmp_loaded), 32'd1);
    chk({tag, "_nwr"}, 32'(n_wr - base), 32'd12);
    chk({tag, "_a0"}, 32'(wa[base]), 32'd0);
    chk({tag, "_d0"}, 32'(wd[base]), 32'h0201);
    chk({tag, "_d1"}, 32'(wd[base + 1]), 32'h0003);
    chk({tag, "_row1_a"}, 32'(wa[base + 6]), 32'd1280);
    chk({tag, "_row1_d"}, 32'(wd[base + 6]), 32'h4241);
    chk({tag, "_row1_d1"}, 32'(wd[base + 7]), 32'h0043);
    chk({tag, "_last_a"}, 32'(wa[base + 11]), 32'd1285);
    chk({tag, "_last_d"}, 32'(wd[base + 11]), 32'h0049);
  endtask

  initial begin
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    repeat (3) @(negedge clk_sys);
    chk("rst_req", 32'(port_req), 32'd0);
    chk("rst_we", 32'(port_we), 32'd0);
    chk("rst_a", 32'(port_a), 32'd0);
    chk("rst_d", 32'(port_d), 32'd0);
    chk("rst_ds", 32'(port_ds), 32'd3);
    chk("rst_loaded", 32'(bmp_loaded), 32'd0);
    chk("rst_error", 32'(bmp_error), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Valid 640x2 image.
    start_dl();
    base = n_wr;
    send_header(8'h4D, 32'd640, 32'd2, 16'd24);
    for (int k = 0; k < 3840; k++) send_byte(54 + k, pix640(k));
    wait_end("v640_timeout", 1000);
    end_dl();
    chk("v640_nwr", 32'(n_wr - base), 32'd2560);
    chk("v640_a0", 32'(wa[base]), 32'd0);
    chk("v640_d0", 32'(wd[base]), 32'h2211);
    chk("v640_a1", 32'(wa[base + 1]), 32'd1);
    chk("v640_d1", 32'(wd[base + 1]), 32'h0033);
    chk("v640_alast", 32'(wa[base + 2559]), 32'd2559);
    chk("v640_dlast", 32'(wd[base + 2559]), 32'h00FF);
    bad_seq = 0;
    for (int k = 0; k < 2560; k++) if (wa[base + k] !== 22'(k)) bad_seq++;
    chk("v640_addr_seq", 32'(bad_seq), 32'd0);
    chk("v640_loaded", 32'(bmp_loaded), 32'd1);
    chk("v640_error", 32'(bmp_error), 32'd0);
    chk("v640_we_idle", 32'(port_we), 32'd0);

    // Bad signature.
    start_dl();
    chk("start_clears_loaded", 32'(bmp_loaded), 32'd0);
    base = n_wr;
    send_header(8'h58, 32'd640, 32'd2, 16'd24);
    end_dl();
    chk("sig_code", 32'(err_code), 32'd1);
    chk("sig_error", 32'(bmp_error), 32'd1);
    chk("sig_nwr", 32'(n_wr - base), 32'd0);

    // 32bpp rejected.
    start_dl();
    base = n_wr;
    send_header(8'h4D, 32'd640, 32'd2, 16'd32);
    for (int k = 0; k < 12; k++) send_byte(54 + k, 8'hAB);
    end_dl();
    chk("bpp_code", 32'(err_code), 32'd2);
    chk("bpp_loaded", 32'(bmp_loaded), 32'd0);
    chk("bpp_nwr", 32'(n_wr - base), 32'd0);

    // 3x2 with 3 pad bytes per row.
    load_3x2("pad");

    // Ack held: overflow after the FIFO fills.
    ack_hold = 1'b1;
    start_dl();
    base = n_wr;
    send_header(8'h4D, 32'd640, 32'd1, 16'd24);
    for (int k = 0; k < 30; k++) send_byte(54 + k, 8'(k));
    chk("ovf_code", 32'(err_code), 32'd4);
    chk("ovf_error", 32'(bmp_error), 32'd1);
    chk("ovf_loaded", 32'(bmp_loaded), 32'd0);
    chk("ovf_pending", 32'(port_req ^ port_ack), 32'd1);
    ack_hold = 1'b0;
    repeat (20) @(negedge clk_sys);
    chk("ovf_ack_done", 32'(port_req ^ port_ack), 32'd0);
    chk("ovf_nwr", 32'(n_wr - base), 32'd1);
    chk("ovf_we", 32'(port_we), 32'd0);
    end_dl();
    chk("ovf_code_hold", 32'(err_code), 32'd4);

    // Download dropped after 100 pixel bytes.
    start_dl();
    send_header(8'h4D, 32'd640, 32'd2, 16'd24);
    for (int k = 0; k < 100; k++) send_byte(54 + k, 8'(k));
    end_dl();
    chk("trunc_code", 32'(err_code), 32'd5);
    chk("trunc_error", 32'(bmp_error), 32'd1);
    chk("trunc_loaded", 32'(bmp_loaded), 32'd0);
    repeat (20) @(negedge clk_sys);

    // Reset pulse mid-upload, then a normal load.
    start_dl();
    chk("start_clears_error", 32'(bmp_error), 32'd0);
    chk("start_clears_code", 32'(err_code), 32'd0);
    send_header(8'h4D, 32'd640, 32'd2, 16'd24);
    for (int k = 0; k < 50; k++) send_byte(54 + k, 8'(k));
    @(negedge clk_sys);
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    #1;
    chk("mid_rst_req", 32'(port_req), 32'd0);
    chk("mid_rst_we", 32'(port_we), 32'd0);
    chk("mid_rst_a", 32'(port_a), 32'd0);
    chk("mid_rst_d", 32'(port_d), 32'd0);
    chk("mid_rst_ds", 32'(port_ds), 32'd3);
    chk("mid_rst_loaded", 32'(bmp_loaded), 32'd0);
    chk("mid_rst_error", 32'(bmp_error), 32'd0);
    chk("mid_rst_code", 32'(err_code), 32'd0);
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    load_3x2("post_rst");
    chk("post_rst_error", 32'(bmp_error), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
